ysyx_22040210_lsu: RTL and testbench

YSYX_22040210_LSU -- requirements
Module: ysyx_22040210_lsu

---
 rtl/ysyx_22040210_lsu.sv | 166 ++++++++++++++++
 tb/tb_ysyx_22040210_lsu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040210_lsu.sv
// Load/store unit: takes one request from execute, runs a single aligned
// data-memory access (with a wait-state timeout) and returns the result to writeback.
module ysyx_22040210_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        ex_ren_i,
  input  logic        ex_wen_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [63:0] ex_addr_i,
  input  logic [63:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_i,
  output logic        wb_valid_o,
  output logic [63:0] wb_rdata_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_err_o,
  output logic        ce_o,
  output logic        memren_o,
  output logic        memwen_o,
  output logic [7:0]  memwe_o,
  output logic [63:0] memraddr_o,
  output logic [63:0] memwaddr_o,
  output logic [63:0] memwdata_o,
  input  logic [63:0] memrdata_i,
  input  logic        memrdatavaild_i,
  input  logic        memwdatavaild_i
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{56{raw[7]}}, raw[7:0]};
      3'b001:  return {{48{raw[15]}}, raw[15:0]};
      3'b010:  return {{32{raw[31]}}, raw[31:0]};
      3'b100:  return {56'd0, raw[7:0]};
      3'b101:  return {48'd0, raw[15:0]};
      3'b110:  return {32'd0, raw[31:0]};
      default: return raw;
    endcase
  endfunction

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             err_p1;
  logic             init_done;
  logic [2:0]       funct3_p0;
  logic [63:0]      addr_p0;
  logic [63:0]      wdata_p0;
  logic [4:0]       rd_p0;
  logic [63:0]      rdata_p1;
  logic             accept;
  logic             req_err;

  assign accept = ex_valid_i && ex_ready_o;

  // Illegal combinations are decided at accept time so no memory access is ever issued for them.
  assign req_err = (ex_ren_i && ex_wen_i)
                || (ex_ren_i && (ex_funct3_i == 3'b111))
                || (ex_wen_i && ex_funct3_i[2])
                || ((ex_ren_i || ex_wen_i) && misaligned(ex_funct3_i[1:0], ex_addr_i[2:0]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err_p1    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          err_p1 <= req_err;
          if (req_err)       state <= RESP;
          else if (ex_ren_i) state <= RD_REQ;
          else if (ex_wen_i) state <= WR_REQ;
          else               state <= RESP;
        end
        RD_REQ: begin
          state <= RD_WAIT;
          cnt   <= '0;
        end
        RD_WAIT: begin
          if (memrdatavaild_i) state <= RESP;
          else if (cnt == CNT_LAST) begin
            state  <= RESP;
            err_p1 <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        end
        WR_REQ: begin
          state <= WR_WAIT;
          cnt   <= '0;
        end
        WR_WAIT: begin
          if (memwdatavaild_i) state <= RESP;
          else if (cnt == CNT_LAST) begin
            state  <= RESP;
            err_p1 <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture (p0) and response data (p1); result stays zero unless a load completes.
  always_ff @(posedge clk) begin
    if (accept) begin
      funct3_p0 <= ex_funct3_i;
      addr_p0   <= ex_addr_i;
      wdata_p0  <= ex_wdata_i;
      rd_p0     <= ex_rd_i;
      rdata_p1  <= '0;
    end else if ((state == RD_WAIT) && memrdatavaild_i) begin
      rdata_p1  <= load_ext(memrdata_i >> {addr_p0[2:0], 3'b000}, funct3_p0);
    end
  end

  logic rd_phase;
  logic wr_phase;
  assign rd_phase = (state == RD_REQ) || (state == RD_WAIT);
  assign wr_phase = (state == WR_REQ) || (state == WR_WAIT);

  assign ex_ready_o = init_done && (state == IDLE);
  assign ce_o       = rd_phase || wr_phase;
  assign memren_o   = (state == RD_REQ);
  assign memwen_o   = (state == WR_REQ);
  assign memraddr_o = rd_phase ? {addr_p0[63:3], 3'b000} : '0;
  assign memwaddr_o = wr_phase ? {addr_p0[63:3], 3'b000} : '0;
  assign memwe_o    = wr_phase ? (size_mask(funct3_p0[1:0]) << addr_p0[2:0]) : '0;
  assign memwdata_o = wr_phase ? (wdata_p0 << {addr_p0[2:0], 3'b000}) : '0;
  assign wb_valid_o = (state == RESP);
  assign wb_rdata_o = wb_valid_o ? rdata_p1 : '0;
  assign wb_rd_o    = wb_valid_o ? rd_p0 : '0;
  assign wb_err_o   = wb_valid_o && err_p1;

endmodule

// File: tb/tb_ysyx_22040210_lsu.sv
// Directed bench for the LSU: loads, stores, error routing, timeout and mid-access reset.
module tb_ysyx_22040210_lsu;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic        ex_ren_i = 1'b0;
  logic        ex_wen_i = 1'b0;
  logic [2:0]  ex_funct3_i = '0;
  logic [63:0] ex_addr_i = '0;
  logic [63:0] ex_wdata_i = '0;
  logic [4:0]  ex_rd_i = '0;
  logic        wb_valid_o;
  logic [63:0] wb_rdata_o;
  logic [4:0]  wb_rd_o;
  logic        wb_err_o;
  logic        ce_o, memren_o, memwen_o;
  logic [7:0]  memwe_o;
  logic [63:0] memraddr_o, memwaddr_o, memwdata_o;
  logic [63:0] memrdata_i = '0;
  logic        memrdatavaild_i = 1'b0;
  logic        memwdatavaild_i = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  ysyx_22040210_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_ren_i(ex_ren_i), .ex_wen_i(ex_wen_i), .ex_funct3_i(ex_funct3_i),
    .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_rd_i(ex_rd_i),
    .wb_valid_o(wb_valid_o), .wb_rdata_o(wb_rdata_o), .wb_rd_o(wb_rd_o), .wb_err_o(wb_err_o),
    .ce_o(ce_o), .memren_o(memren_o), .memwen_o(memwen_o), .memwe_o(memwe_o),
    .memraddr_o(memraddr_o), .memwaddr_o(memwaddr_o), .memwdata_o(memwdata_o),
    .memrdata_i(memrdata_i), .memrdatavaild_i(memrdatavaild_i), .memwdatavaild_i(memwdatavaild_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits for ready, and returns one cycle after the accepting edge (T+1).
  task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
    int guard = 0;
    ex_valid_i = 1'b1; ex_ren_i = ren; ex_wen_i = wen; ex_funct3_i = f3;
    ex_addr_i = addr; ex_wdata_i = wdata; ex_rd_i = rd;
    while (ex_ready_o !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    if (guard == 20) check("ready_wait", 64'(ex_ready_o), 64'd1);
    step();
    ex_valid_i = 1'b0; ex_ren_i = 1'b0; ex_wen_i = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] exp_raddr, input logic [63:0] mdata,
                         input logic [4:0] rd, input int waits, input logic [63:0] exp);
    issue(1'b1, 1'b0, f3, addr, 64'hDEAD_BEEF, rd);
    check({tag, "_memren_t1"}, 64'(memren_o), 64'd1);
    check({tag, "_raddr"}, memraddr_o, exp_raddr);
    check({tag, "_ce"}, 64'(ce_o), 64'd1);
    step();
    check({tag, "_memren_t2"}, 64'(memren_o), 64'd0);
    for (int i = 0; i < waits; i++) begin
      memwdatavaild_i = 1'b1;
      step();
      check({tag, "_wait_novalid"}, 64'(wb_valid_o), 64'd0);
    end
    memwdatavaild_i = 1'b0;
    memrdata_i = mdata; memrdatavaild_i = 1'b1;
    step();
    memrdatavaild_i = 1'b0; memrdata_i = '0;
    check({tag, "_wbvalid"}, 64'(wb_valid_o), 64'd1);
    check({tag, "_rdata"}, wb_rdata_o, exp);
    check({tag, "_err"}, 64'(wb_err_o), 64'd0);
    check({tag, "_rd"}, 64'(wb_rd_o), 64'(rd));
    step();
    check({tag, "_wbvalid_once"}, 64'(wb_valid_o), 64'd0);
    check({tag, "_ready_back"}, 64'(ex_ready_o), 64'd1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] exp_we,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_waddr);
    issue(1'b0, 1'b1, f3, addr, wdata, 5'd7);
    check({tag, "_memwen_t1"}, 64'(memwen_o), 64'd1);
    check({tag, "_memren_t1"}, 64'(memren_o), 64'd0);
    check({tag, "_we"}, 64'(memwe_o), 64'(exp_we));
    check({tag, "_wdata"}, memwdata_o, exp_wdata);
    check({tag, "_waddr"}, memwaddr_o, exp_waddr);
    step();
    check({tag, "_memwen_t2"}, 64'(memwen_o), 64'd0);
    memwdatavaild_i = 1'b1;
    step();
    memwdatavaild_i = 1'b0;
    check({tag, "_wbvalid"}, 64'(wb_valid_o), 64'd1);
    check({tag, "_rdata"}, wb_rdata_o, 64'd0);
    check({tag, "_err"}, 64'(wb_err_o), 64'd0);
    step();
    check({tag, "_ready_back"}, 64'(ex_ready_o), 64'd1);
  endtask

  task automatic do_quick(input string tag, input logic ren, input logic wen, input logic [2:0] f3,
                          input logic [63:0] addr, input logic exp_err);
    issue(ren, wen, f3, addr, 64'h1234, 5'd9);
    check({tag, "_no_memren"}, 64'(memren_o), 64'd0);
    check({tag, "_no_memwen"}, 64'(memwen_o), 64'd0);
    check({tag, "_wbvalid"}, 64'(wb_valid_o), 64'd1);
    check({tag, "_err"}, 64'(wb_err_o), 64'(exp_err));
    check({tag, "_rdata"}, wb_rdata_o, 64'd0);
    check({tag, "_rd"}, 64'(wb_rd_o), 64'd9);
    step();
    check({tag, "_ready_back"}, 64'(ex_ready_o), 64'd1);
  endtask

  initial begin
    #3;
    check("rst_ready", 64'(ex_ready_o), 64'd0);
    check("rst_wbvalid", 64'(wb_valid_o), 64'd0);
    check("rst_ce", 64'(ce_o), 64'd0);
    repeat (2) step();
    check("rst_ready_hold", 64'(ex_ready_o), 64'd0);
    rst = 1'b1;
    check("release_ready_pre_edge", 64'(ex_ready_o), 64'd0);
    step();
    check("release_ready_edge", 64'(ex_ready_o), 64'd1);

    do_load("ld", 3'b011, 64'h8000_0010, 64'h8000_0010, 64'h1122_3344_5566_7788, 5'd3, 0,
            64'h1122_3344_5566_7788);
    do_load("lb", 3'b000, 64'h8000_0013, 64'h8000_0010, 64'h0000_0000_F000_0000, 5'd4, 0,
            64'hFFFF_FFFF_FFFF_FFF0);
    do_load("lbu", 3'b100, 64'h8000_0013, 64'h8000_0010, 64'h0000_0000_F000_0000, 5'd5, 0,
            64'h0000_0000_0000_00F0);
    do_load("lh", 3'b001, 64'h8000_0002, 64'h8000_0000, 64'h0000_0000_8001_0000, 5'd6, 2,
            64'hFFFF_FFFF_FFFF_8001);
    do_load("lhu", 3'b101, 64'h8000_0002, 64'h8000_0000, 64'h0000_0000_8001_0000, 5'd6, 0,
            64'h0000_0000_0000_8001);
    do_load("lw", 3'b010, 64'h8000_000C, 64'h8000_0008, 64'h8000_0001_0000_0000, 5'd10, 0,
            64'hFFFF_FFFF_8000_0001);
    do_load("lwu", 3'b110, 64'h8000_000C, 64'h8000_0008, 64'h8000_0001_0000_0000, 5'd11, 1,
            64'h0000_0000_8000_0001);

    do_store("sh", 3'b001, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 8'hC0,
             64'hABCD_0000_0000_0000, 64'h8000_0000);
    do_store("sd", 3'b011, 64'h8000_0008, 64'h0102_0304_0506_0708, 8'hFF,
             64'h0102_0304_0506_0708, 64'h8000_0008);
    do_store("sb", 3'b000, 64'h8000_0005, 64'h0000_0000_0000_00AA, 8'h20,
             64'h0000_AA00_0000_0000, 64'h8000_0000);
    do_store("sw", 3'b010, 64'h8000_0014, 64'h0000_0000_CAFE_F00D, 8'hF0,
             64'hCAFE_F00D_0000_0000, 64'h8000_0010);

    do_quick("lw_misal", 1'b1, 1'b0, 3'b010, 64'h8000_0002, 1'b1);
    do_quick("ren_wen", 1'b1, 1'b1, 3'b011, 64'h8000_0000, 1'b1);
    do_quick("ld_f3_111", 1'b1, 1'b0, 3'b111, 64'h8000_0000, 1'b1);
    do_quick("st_f3_100", 1'b0, 1'b1, 3'b100, 64'h8000_0000, 1'b1);
    do_quick("sd_misal", 1'b0, 1'b1, 3'b011, 64'h8000_0004, 1'b1);
    do_quick("lh_misal", 1'b1, 1'b0, 3'b001, 64'h8000_0001, 1'b1);
    do_quick("noop", 1'b0, 1'b0, 3'b011, 64'h8000_0003, 1'b0);

    // Read timeout: valid never arrives.
    issue(1'b1, 1'b0, 3'b011, 64'h8000_0020, 64'd0, 5'd12);
    check("to_memren", 64'(memren_o), 64'd1);
    for (int i = 0; i < TO; i++) begin
      step();
      check("to_waiting", 64'(wb_valid_o), 64'd0);
    end
    step();
    check("to_wbvalid", 64'(wb_valid_o), 64'd1);
    check("to_err", 64'(wb_err_o), 64'd1);
    check("to_rdata", wb_rdata_o, 64'd0);
    step();
    check("to_ready", 64'(ex_ready_o), 64'd1);

    // Reset in the middle of a read wait.
    issue(1'b1, 1'b0, 3'b011, 64'h8000_0030, 64'd0, 5'd13);
    step();
    check("mid_ce_before", 64'(ce_o), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_ce", 64'(ce_o), 64'd0);
    check("mid_ready", 64'(ex_ready_o), 64'd0);
    check("mid_raddr", memraddr_o, 64'd0);
    memrdata_i = 64'h5555; memrdatavaild_i = 1'b1;
    step();
    check("mid_wbvalid_rst", 64'(wb_valid_o), 64'd0);
    rst = 1'b1;
    memrdatavaild_i = 1'b0; memrdata_i = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_wbvalid", 64'(wb_valid_o), 64'd0);
      check("post_rst_memren", 64'(memren_o), 64'd0);
    end
    do_load("ld_after_rst", 3'b011, 64'h8000_0040, 64'h8000_0040, 64'hA5A5_0000_1234_5678, 5'd14, 0,
            64'hA5A5_0000_1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
